// File: rtl/load_response_queue_pkg.sv
// Shared io-stage types: load kinds, queue entry layout, datapath width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package io_stage_params;

  localparam int CPU_DATA_WIDTH = 32;

  // Widest destination tag an entry can hold; narrower tags are zero-extended.
  localparam int TAG_WIDTH_MAX = 8;

  typedef enum logic [2:0] {
    KIND_LB    = 3'd0,
    KIND_LH    = 3'd1,
    KIND_LW    = 3'd2,
    KIND_LWL   = 3'd3,
    KIND_LWR   = 3'd4,
    KIND_STORE = 3'd5
  } load_kind_t;

  // FREE must encode as zero so a cleared entry is free.
  typedef enum logic [1:0] {
    ENT_FREE    = 2'd0,
    ENT_PENDING = 2'd1,
    ENT_DONE    = 2'd2
  } entry_state_t;

  typedef struct packed {
    entry_state_t                state;
    logic                        discard;
    load_kind_t                  kind;
    logic                        is_unsigned;
    logic [1:0]                  offset;
    logic [TAG_WIDTH_MAX-1:0]    tag;
    logic [CPU_DATA_WIDTH-1:0]   data;
  } load_queue_entry_t;

endpackage

// File: rtl/load_response_queue_align.sv
// Load data aligner: byte/half select with extension, LWL/LWR shifts and strobes.
// Latency: purely combinational, 0 cycles.
// Backpressure: none (no handshake).
// Ports: kind_i, is_unsigned_i, offset_i, data_i -> data_o (aligned), strobe_o (RF byte strobe).
module load_data_align
  import io_stage_params::*;
(
  input  load_kind_t                kind_i,
  input  logic                      is_unsigned_i,
  input  logic [1:0]                offset_i,
  input  logic [CPU_DATA_WIDTH-1:0] data_i,
  output logic [CPU_DATA_WIDTH-1:0] data_o,
  output logic [3:0]                strobe_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [1:0]  lwl_sh;

  always_comb begin
    byte_sel = data_i[{offset_i, 3'b000} +: 8];
    half_sel = offset_i[1] ? data_i[31:16] : data_i[15:0];
    lwl_sh   = 2'd3 - offset_i;
    data_o   = data_i;
    strobe_o = 4'b1111;
    case (kind_i)
      KIND_LB:  data_o = {{24{byte_sel[7] & ~is_unsigned_i}}, byte_sel};
      KIND_LH:  data_o = {{16{half_sel[15] & ~is_unsigned_i}}, half_sel};
      // LWL fills the upper bytes of the register from the low bytes of memory.
      KIND_LWL: begin
        data_o   = data_i << {lwl_sh, 3'b000};
        strobe_o = 4'b1111 << lwl_sh;
      end
      // LWR fills the lower bytes of the register from the high bytes of memory.
      KIND_LWR: begin
        data_o   = data_i >> {offset_i, 3'b000};
        strobe_o = 4'b1111 >> offset_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_response_queue.sv
// In-order queue of outstanding data-SRAM transactions; aligns load results for the io stage.
// Latency: response -> out_valid 1 cycle (0 cycles with LOAD_QUEUE_BYPASS_EN defined).
// Backpressure: req_ready low when full; responses cannot stall and are held until out_ready.
// Ports: req_* allocate, resp_* fill oldest pending entry, out_* valid/ready result,
//        flush cancels queued entries, occupancy live count, orphan_resp sticky error.
// Optional: LOAD_QUEUE_BYPASS_EN enables a same-cycle response-to-output bypass at the head.
module load_response_queue
  import io_stage_params::*;
#(
  parameter int DEPTH     = 4,
  parameter int TAG_WIDTH = 5
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  load_kind_t                req_kind,
  input  logic                      req_unsigned,
  input  logic [1:0]                req_offset,
  input  logic [TAG_WIDTH-1:0]      req_tag,
  input  logic                      flush,
  input  logic                      resp_valid,
  input  logic [CPU_DATA_WIDTH-1:0] resp_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CPU_DATA_WIDTH-1:0] out_data,
  output logic [3:0]                out_strobe,
  output logic [TAG_WIDTH-1:0]      out_tag,
  output logic [$clog2(DEPTH):0]    occupancy,
  output logic                      orphan_resp
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  load_queue_entry_t ent_q [DEPTH];
  load_queue_entry_t ent_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, fill_q, fill_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              orphan_q, orphan_d;

  load_queue_entry_t         head_ent;
  logic                      head_is_load;
  logic                      alloc, fill_hit, done_out, retire, bypass_hit, free_head;
  logic [CPU_DATA_WIDTH-1:0] align_in, align_out;
  logic [3:0]                align_strobe;

  assign head_ent     = ent_q[head_q];
  assign head_is_load = (head_ent.kind != KIND_STORE);
  assign req_ready    = (count_q < CNT_W'(DEPTH));
  assign alloc        = req_valid && req_ready;
  // fill always points at the oldest PENDING entry, or at a non-pending slot when none exist.
  assign fill_hit     = resp_valid && (ent_q[fill_q].state == ENT_PENDING);
  assign done_out     = (head_ent.state == ENT_DONE) && !head_ent.discard && head_is_load;
  assign retire       = (head_ent.state == ENT_DONE) && (head_ent.discard || !head_is_load);

`ifdef LOAD_QUEUE_BYPASS_EN
  // A pending head is necessarily the oldest pending entry, so fill_q == head_q here.
  assign bypass_hit = resp_valid && (head_ent.state == ENT_PENDING) && !head_ent.discard
                      && head_is_load && (fill_q == head_q);
`else
  assign bypass_hit = 1'b0;
`endif

  assign out_valid = done_out || bypass_hit;
  assign free_head = retire || (out_valid && out_ready);
  assign align_in  = bypass_hit ? resp_data : head_ent.data;

  load_data_align u_align (
    .kind_i        (head_ent.kind),
    .is_unsigned_i (head_ent.is_unsigned),
    .offset_i      (head_ent.offset),
    .data_i        (align_in),
    .data_o        (align_out),
    .strobe_o      (align_strobe)
  );

  // Outputs are forced to zero when idle so nothing stale leaks to the io stage.
  assign out_data    = out_valid ? align_out : '0;
  assign out_strobe  = out_valid ? align_strobe : 4'b0000;
  assign out_tag     = out_valid ? TAG_WIDTH'(head_ent.tag) : '0;
  assign occupancy   = count_q;
  assign orphan_resp = orphan_q;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      // Flush only marks entries that exist before this edge; the allocation below is untouched.
      if (flush && (ent_q[i].state != ENT_FREE)) begin
        ent_d[i].discard = 1'b1;
      end
    end
    head_d   = head_q;
    fill_d   = fill_q;
    tail_d   = tail_q;
    orphan_d = orphan_q | (resp_valid && !fill_hit);

    if (fill_hit) begin
      ent_d[fill_q].state = ENT_DONE;
      ent_d[fill_q].data  = resp_data;
      fill_d              = fill_q + 1'b1;
    end

    // Applied after the fill so a bypassed head goes straight to FREE.
    if (free_head) begin
      ent_d[head_q].state   = ENT_FREE;
      ent_d[head_q].discard = 1'b0;
      head_d                = head_q + 1'b1;
    end

    if (alloc) begin
      ent_d[tail_q] = '{state:       ENT_PENDING,
                        discard:     1'b0,
                        kind:        req_kind,
                        is_unsigned: req_unsigned,
                        offset:      req_offset,
                        tag:         TAG_WIDTH_MAX'(req_tag),
                        data:        '0};
      tail_d = tail_q + 1'b1;
    end

    count_d = count_q + CNT_W'(alloc) - CNT_W'(free_head);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      head_q   <= '0;
      fill_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      orphan_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      head_q   <= head_d;
      fill_q   <= fill_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      orphan_q <= orphan_d;
    end
  end

endmodule

// File: tb/tb_load_response_queue.sv
// Directed bench for load_response_queue (DEPTH=4, TAG_WIDTH=5, bypass disabled).
module tb_load_response_queue;
  import io_stage_params::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  load_kind_t  req_kind;
  logic        req_unsigned;
  logic [1:0]  req_offset;
  logic [4:0]  req_tag;
  logic        flush;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_strobe;
  logic [4:0]  out_tag;
  logic [2:0]  occupancy;
  logic        orphan_resp;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clock = ~clock;

  load_response_queue #(.DEPTH(4), .TAG_WIDTH(5)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_kind     (req_kind),
    .req_unsigned (req_unsigned),
    .req_offset   (req_offset),
    .req_tag      (req_tag),
    .flush        (flush),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_strobe   (out_strobe),
    .out_tag      (out_tag),
    .occupancy    (occupancy),
    .orphan_resp  (orphan_resp)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input load_kind_t k, input logic u, input logic [1:0] off,
                       input logic [4:0] t);
    req_valid = 1'b1; req_kind = k; req_unsigned = u; req_offset = off; req_tag = t;
    step();
    req_valid = 1'b0;
  endtask

  task automatic resp(input logic [31:0] d);
    resp_valid = 1'b1; resp_data = d;
    step();
    resp_valid = 1'b0;
  endtask

  task automatic drain_one(input string nm, input logic [31:0] d, input logic [3:0] s,
                           input logic [4:0] t);
    chk({nm, ".valid"}, 32'(out_valid), 32'd1);
    chk({nm, ".data"}, out_data, d);
    chk({nm, ".strobe"}, 32'(out_strobe), 32'(s));
    chk({nm, ".tag"}, 32'(out_tag), 32'(t));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_kind = KIND_LW; req_unsigned = 1'b0;
    req_offset = 2'd0; req_tag = 5'd0; flush = 1'b0; resp_valid = 1'b0;
    resp_data = 32'd0; out_ready = 1'b0;
    do_reset();

    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_data", out_data, 32'd0);
    chk("rst.out_strobe", 32'(out_strobe), 32'd0);
    chk("rst.out_tag", 32'(out_tag), 32'd0);
    chk("rst.occupancy", 32'(occupancy), 32'd0);
    chk("rst.orphan", 32'(orphan_resp), 32'd0);
    chk("rst.req_ready", 32'(req_ready), 32'd1);

    // Signed byte load, result one cycle after the response.
    issue(KIND_LB, 1'b0, 2'd2, 5'd3);
    chk("lb.occ", 32'(occupancy), 32'd1);
    chk("lb.pending_no_out", 32'(out_valid), 32'd0);
    resp(32'h12F45678);
    drain_one("lb", 32'hFFFFFFF4, 4'b1111, 5'd3);
    chk("lb.occ_after", 32'(occupancy), 32'd0);

    issue(KIND_LB, 1'b1, 2'd2, 5'd4);
    resp(32'h12F45678);
    drain_one("lbu", 32'h000000F4, 4'b1111, 5'd4);

    issue(KIND_LH, 1'b0, 2'd2, 5'd2);
    resp(32'h80011234);
    drain_one("lh", 32'hFFFF8001, 4'b1111, 5'd2);

    issue(KIND_LWL, 1'b0, 2'd1, 5'd7);
    resp(32'hAABBCCDD);
    drain_one("lwl", 32'hCCDD0000, 4'b1100, 5'd7);

    issue(KIND_LWR, 1'b0, 2'd1, 5'd8);
    resp(32'hAABBCCDD);
    drain_one("lwr", 32'h00AABBCC, 4'b0111, 5'd8);

    issue(KIND_LW, 1'b0, 2'd3, 5'd31);
    resp(32'hDEADBEEF);
    // Allocate and free in the same cycle: occupancy stays at one.
    chk("simul.valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    issue(KIND_LW, 1'b0, 2'd0, 5'd1);
    out_ready = 1'b0;
    chk("simul.occ", 32'(occupancy), 32'd1);
    chk("simul.no_out", 32'(out_valid), 32'd0);
    resp(32'h01020304);
    drain_one("simul.lw", 32'h01020304, 4'b1111, 5'd1);

    // Fill the queue, hold results, then drain in order.
    for (int i = 0; i < 4; i++) issue(KIND_LW, 1'b0, 2'd0, 5'(10 + i));
    chk("full.req_ready", 32'(req_ready), 32'd0);
    chk("full.occ", 32'(occupancy), 32'd4);
    issue(KIND_LW, 1'b0, 2'd0, 5'd20);
    chk("full.ignored_occ", 32'(occupancy), 32'd4);
    for (int i = 0; i < 4; i++) resp(32'h11111111 * (i + 1));
    chk("full.held_occ", 32'(occupancy), 32'd4);
    chk("full.held_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < 4; i++) drain_one("full.out", 32'h11111111 * (i + 1), 4'b1111, 5'(10 + i));
    chk("full.empty_occ", 32'(occupancy), 32'd0);
    chk("full.empty_valid", 32'(out_valid), 32'd0);

    // Flush with two outstanding; the load accepted in the flush cycle survives.
    issue(KIND_LW, 1'b0, 2'd0, 5'd4);
    issue(KIND_LW, 1'b0, 2'd0, 5'd5);
    flush = 1'b1;
    issue(KIND_LW, 1'b0, 2'd0, 5'd6);
    flush = 1'b0;
    chk("flush.occ", 32'(occupancy), 32'd3);
    resp(32'hA0A0A0A0);
    chk("flush.r1_no_out", 32'(out_valid), 32'd0);
    resp(32'hB0B0B0B0);
    chk("flush.r2_no_out", 32'(out_valid), 32'd0);
    resp(32'hC0C0C0C0);
    drain_one("flush.live", 32'hC0C0C0C0, 4'b1111, 5'd6);
    chk("flush.end_valid", 32'(out_valid), 32'd0);
    chk("flush.end_occ", 32'(occupancy), 32'd0);

    // Store retires silently ahead of a load.
    issue(KIND_STORE, 1'b0, 2'd0, 5'd8);
    issue(KIND_LW, 1'b0, 2'd0, 5'd9);
    resp(32'h00000001);
    chk("store.no_out", 32'(out_valid), 32'd0);
    resp(32'h55AA55AA);
    drain_one("store.lw", 32'h55AA55AA, 4'b1111, 5'd9);
    chk("store.end_occ", 32'(occupancy), 32'd0);
    chk("store.no_orphan", 32'(orphan_resp), 32'd0);

    // Orphan response on an empty queue is sticky until reset.
    resp(32'h12345678);
    chk("orphan.set", 32'(orphan_resp), 32'd1);
    chk("orphan.occ", 32'(occupancy), 32'd0);
    step();
    step();
    chk("orphan.sticky", 32'(orphan_resp), 32'd1);
    do_reset();
    chk("orphan.rst_clear", 32'(orphan_resp), 32'd0);
    chk("orphan.rst_occ", 32'(occupancy), 32'd0);

    // Reset mid-operation drops the pending load; its response becomes an orphan.
    issue(KIND_LW, 1'b0, 2'd0, 5'd3);
    do_reset();
    chk("midrst.occ", 32'(occupancy), 32'd0);
    resp(32'hFEEDFACE);
    chk("midrst.orphan", 32'(orphan_resp), 32'd1);
    chk("midrst.no_out", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/load_response_queue.md
Name: load_response_queue

Overview:
- Parametrised successor to the io-stage load path. Replaces the single pending-load counter with an in-order queue of up to DEPTH outstanding data-SRAM transactions.
- Data-SRAM responses cannot be back-pressured. The queue matches each response to its oldest pending transaction, aligns and extends load data, and generates register-file write strobes for LWL/LWR.
- Holds results until the io stage accepts them, and silently retires responses that belong to flushed transactions.

Parameters:
- DEPTH, 4, maximum outstanding transactions; power of two, at least 2.
- TAG_WIDTH, 5, width of the destination-register tag carried with each load.

Ports:
- clock  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  transaction issued to data SRAM this cycle.
- req_ready  out  1  queue can accept a request (not full).
- req_kind  in  3  load_kind_t: LB, LH, LW, LWL, LWR, STORE.
- req_unsigned  in  1  zero-extend LB/LH.
- req_offset  in  2  memory_address[1:0].
- req_tag  in  TAG_WIDTH  destination register.
- flush  in  1  exception or eret flush; cancels every entry already in the queue.
- resp_valid  in  1  data_ram_data_ready.
- resp_data  in  32  data_ram_read_data.
- out_valid  out  1  aligned load result available.
- out_ready  in  1  io stage consumes the result.
- out_data  out  32  aligned and extended data.
- out_strobe  out  4  register-file byte write strobe.
- out_tag  out  TAG_WIDTH  destination register.
- occupancy  out  $clog2(DEPTH)+1  live entry count.
- orphan_resp  out  1  sticky: a response arrived with no pending entry.

Behaviour:
- Storage is a circular buffer of DEPTH entries with three pointers: head (output), fill (oldest PENDING), tail (allocation). Pointers wrap modulo DEPTH.
- Entry state is FREE -> PENDING -> DONE -> FREE. Each entry also carries a discard bit and its request fields.
- Allocation: req_valid && req_ready writes the entry at tail as PENDING with discard=0, then advances tail. req_ready = (occupancy < DEPTH). A req_valid while full is ignored.
- Fill: when resp_valid and the entry at fill is PENDING, capture resp_data, mark the entry DONE, and advance fill.
- Orphan response: if resp_valid arrives with no PENDING entry, drop it and set orphan_resp. orphan_resp clears only on reset.
- Retire: if the head entry is DONE and (discard or kind==STORE), free it without output in that cycle and advance head.
- Output: if the head entry is DONE, live, and a load, assert out_valid. out_valid && out_ready frees the head entry and advances head.
- Throughput: at most one retire or one output per cycle.
- Latency: response to out_valid is 1 cycle (registered).
- Flush: sets discard on every non-FREE entry at the clock edge.
  - A request accepted in the same cycle as flush is not discarded.
  - A response arriving in the flush cycle still fills its entry, which is then discarded.
- Simultaneous allocate and free in one cycle: occupancy is unchanged. A full queue that frees in a cycle still deasserts req_ready for that cycle; no combinational ready-through.
- Alignment (o = offset, d = resp_data):
  - LB: byte o, sign-extended unless req_unsigned.
  - LH: d[15:0] if o[1]==0, else d[31:16], sign-extended unless req_unsigned.
  - LW: d unmodified.
  - LWL: d shifted left by 8*(3-o). Strobe for o=0..3 is 1000, 1100, 1110, 1111.
  - LWR: d shifted right by 8*o. Strobe for o=0..3 is 1111, 0111, 0011, 0001.
  - Strobe is 1111 for every kind except LWL/LWR.
  - Misalignment is checked upstream and is not handled here.
- Reset: all entries FREE, all pointers 0, out_valid=0, out_data=0, out_strobe=0, out_tag=0, occupancy=0, orphan_resp=0, req_ready=1. Reset mid-operation discards everything immediately; responses arriving after reset become orphans.

Optional Feature:
- Macro LOAD_QUEUE_BYPASS_EN.
- Defined: when the head entry is PENDING, live, and a load, and resp_valid hits it, out_valid and the aligned result are driven combinationally in that cycle (0-cycle latency). If out_ready is also high, the entry frees without ever reaching DONE; otherwise it stores as DONE normally.
- Undefined: 1-cycle latency only; all outputs come from entry state.

Decomposition:
- Shared package io_stage_params:
  - load_kind_t enum.
  - load_queue_entry_t struct: state, discard, kind, unsigned, offset, tag, data.
  - CPU_DATA_WIDTH=32.
- Sub-module load_data_align: purely combinational (kind, unsigned, offset, data) -> (out_data, out_strobe). It is shared with the bypass path.

Test Plan:
- LB at offset 2 with resp_data 0x12F45678, signed -> out_data 0xFFFFFFF4, strobe 1111, 1 cycle after resp. LBU at the same offset -> 0x000000F4.
- LWL at offset 1 with resp_data 0xAABBCCDD -> out_data 0xCCDD0000, strobe 1100. LWR at offset 1 -> 0x00AABBCC, strobe 0111.
- Issue 4 loads (DEPTH=4) -> req_ready=0, occupancy=4. Hold out_ready=0 while 4 responses arrive -> all captured. Release -> 4 results in order, tags intact.
- 2 loads outstanding, flush, 1 new load, then 3 responses -> exactly one out_valid, carrying the new load's tag.
- STORE, then LW, then 2 responses -> store retires silently; one output for the LW.
- resp_valid with empty queue -> orphan_resp=1 and stays set. Reset -> orphan_resp=0, occupancy=0.
